// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with req/ack data port, lane alignment, load extension and WB registers
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALURES,
  input  logic [31:0] MEMDATA,
  input  logic [31:0] MEMHILO,
  input  logic [31:0] MEMPC,
  input  logic [6:0]  EXEDES,
  input  logic [1:0]  EXEWRITEHILO,
  input  logic [31:0] CONTROLW_EXE,
  input  logic [7:0]  INTCONTROLW_EXE,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        MEMSTALL,
  output logic [6:0]  MEMFWDDES,
  output logic [31:0] MEMFWDRES,
  output logic [31:0] WBRES,
  output logic [31:0] WBHILO,
  output logic [31:0] WBPC,
  output logic [6:0]  WBDES,
  output logic [1:0]  WBWRITEHILO,
  output logic [31:0] CONTROLW_MEM,
  output logic [7:0]  INTCONTROLW_MEM
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [31:0] wb_res_q, wb_res_d, wb_hilo_q, wb_hilo_d, wb_pc_q, wb_pc_d, ctrl_q, ctrl_d;
  logic [6:0] wb_des_q, wb_des_d;
  logic [1:0] wb_hilo_we_q, wb_hilo_we_d;
  logic [7:0] int_q, int_d;
  logic mem_op, is_load, is_store, is_word, is_half, sext, addr_err, go, capture;
  logic [1:0] lane;
  logic [31:0] shifted, load_data;
  logic unused_ok;
  assign lane = ALURES[1:0];
  assign is_load = CONTROLW_EXE[8];
  assign is_store = CONTROLW_EXE[9];
  assign mem_op = is_load | is_store;
  assign is_word = CONTROLW_EXE[11];
  assign is_half = CONTROLW_EXE[11:10] == 2'b01;
  assign sext = ~CONTROLW_EXE[12];
  assign addr_err = mem_op & ((is_word & (lane != 2'b00)) | (is_half & lane[0]));
  assign go = mem_op & ~addr_err & ~INTCONTROLW_EXE[2];
  assign unused_ok = ^{INTCONTROLW_EXE[3], shifted[31:16]};
  always_comb begin
    shifted = DMEM_RDATA >> {lane, 3'b000};
    load_data = is_word ? DMEM_RDATA
              : is_half ? {{16{sext & shifted[15]}}, shifted[15:0]}
              : {{24{sext & shifted[7]}}, shifted[7:0]};
    DMEM_REQ = state_q == ACCESS;
    DMEM_WE = DMEM_REQ & is_store;
    DMEM_ADDR = {ALURES[31:2], 2'b00};
    DMEM_BE = is_word ? 4'b1111 : is_half ? 4'b0011 << lane : 4'b0001 << lane;
    DMEM_WDATA = is_word ? MEMDATA : is_half ? {2{MEMDATA[15:0]}} : {4{MEMDATA[7:0]}};
    MEMSTALL = (state_q == IDLE) ? go : ~DMEM_ACK;
    capture = ~MEMSTALL;
    state_d = (state_q == IDLE) ? (go ? ACCESS : IDLE) : (DMEM_ACK ? IDLE : ACCESS);
    // a pending load's data is not in MEMFWDRES, so hide its tag from forwarding
    MEMFWDDES = (go & is_load) ? 7'd0 : EXEDES;
    MEMFWDRES = ALURES;
    wb_res_d = capture ? ((go & is_load) ? load_data : ALURES) : 32'd0;
    wb_hilo_d = capture ? MEMHILO : 32'd0;
    wb_pc_d = capture ? MEMPC : 32'd0;
    wb_des_d = capture ? EXEDES : 7'd0;
    wb_hilo_we_d = capture ? EXEWRITEHILO : 2'd0;
    ctrl_d = capture ? CONTROLW_EXE : 32'd0;
    int_d = capture ? {INTCONTROLW_EXE[7:4], addr_err, INTCONTROLW_EXE[2:0]} : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wb_res_q <= '0;
      wb_hilo_q <= '0;
      wb_pc_q <= '0;
      wb_des_q <= '0;
      wb_hilo_we_q <= '0;
      ctrl_q <= '0;
      int_q <= '0;
    end else begin
      state_q <= state_d;
      wb_res_q <= wb_res_d;
      wb_hilo_q <= wb_hilo_d;
      wb_pc_q <= wb_pc_d;
      wb_des_q <= wb_des_d;
      wb_hilo_we_q <= wb_hilo_we_d;
      ctrl_q <= ctrl_d;
      int_q <= int_d;
    end
  end
  assign WBRES = wb_res_q;
  assign WBHILO = wb_hilo_q;
  assign WBPC = wb_pc_q;
  assign WBDES = wb_des_q;
  assign WBWRITEHILO = wb_hilo_we_q;
  assign CONTROLW_MEM = ctrl_q;
  assign INTCONTROLW_MEM = int_q;
endmodule
